// File: rtl/gpio_port_bank_pkg.sv
// Shared definitions for the GPIO port bank: register select codes and
// the arm-counter threshold that masks edges during synchroniser fill.
package gpio_port_bank_pkg;

  typedef logic [2:0] reg_sel_t;

  localparam reg_sel_t SEL_DATA = 3'b000;
  localparam reg_sel_t SEL_DDR  = 3'b001;
  localparam reg_sel_t SEL_IER  = 3'b010;
  localparam reg_sel_t SEL_EPR  = 3'b011;
  localparam reg_sel_t SEL_IFR  = 3'b100;

  // Cycles after reset before edges may set flags (covers the 2-flop fill).
  localparam int ARM_CYCLES = 3;

endpackage

// File: rtl/gpio_port_sync.sv
// Per-port pad input synchroniser (two flops). When GPIO_PORT_BANK_IRQ_EN is
// defined it also keeps the previous synchronised value and produces
// polarity-selected edge pulses for input-direction bits.
module gpio_port_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin_i,
`ifdef GPIO_PORT_BANK_IRQ_EN
  input  logic [WIDTH-1:0] epr_i,
  input  logic [WIDTH-1:0] ddr_i,
  output logic [WIDTH-1:0] edge_o,
`endif
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] sync1_q, sync2_q;

  // Two-flop synchroniser for the asynchronous pad inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  assign sync_o = sync2_q;

`ifdef GPIO_PORT_BANK_IRQ_EN
  logic [WIDTH-1:0] prev_q;

  // Previous synchronised value, used to spot transitions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= sync2_q;
  end

  // Edge of the selected polarity, only on bits configured as inputs
  assign edge_o = (sync2_q ^ prev_q)
                & ((epr_i & sync2_q) | (~epr_i & ~sync2_q))
                & ~ddr_i;
`endif

endmodule

// File: rtl/gpio_port_bank.sv
// NUM_PORTS x WIDTH GPIO bank with data/direction registers, synchronised
// pin reads and a registered read port (DO/OE). Optional macro
// GPIO_PORT_BANK_IRQ_EN adds IER/EPR/IFR, edge interrupts and irq_n;
// without it irq_n is tied high and those selects read as zero.
module gpio_port_bank
  import gpio_port_bank_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = $clog2(NUM_PORTS) + 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cs,
  input  logic                       we_n,
  input  logic [ADDR_W-1:0]          A,
  input  logic [WIDTH-1:0]           DI,
  output logic [WIDTH-1:0]           DO,
  output logic                       OE,
  input  logic [NUM_PORTS*WIDTH-1:0] PI,
  output logic [NUM_PORTS*WIDTH-1:0] PO,
  output logic [NUM_PORTS*WIDTH-1:0] DDR,
  output logic                       irq_n
);

  reg_sel_t                   sel;
  logic [ADDR_W-1:0]          port_idx;
  logic                       wr_en, rd_en;
  logic [NUM_PORTS*WIDTH-1:0] po_all, ddr_all, sync_all;
  logic [WIDTH-1:0]           rd_data_d;
  logic [WIDTH-1:0]           dout_q;
  logic                       oe_q;

  assign sel      = A[2:0];
  assign port_idx = A >> 3;
  assign wr_en    = cs & ~we_n;
  assign rd_en    = cs & we_n;

`ifdef GPIO_PORT_BANK_IRQ_EN
  logic [NUM_PORTS*WIDTH-1:0] ier_all, epr_all, ifr_all;
  logic [1:0]                 arm_q;
  logic                       armed;
  logic                       irq_q;

  assign armed = (arm_q == 2'(ARM_CYCLES));

  // Arm counter: saturates so edges from the post-reset sync fill are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      arm_q <= '0;
    else if (!armed) arm_q <= arm_q + 2'd1;
  end

  // Interrupt output, registered one cycle behind IFR/IER
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b1;
    else        irq_q <= ~|(ifr_all & ier_all);
  end

  assign irq_n = irq_q;
`else
  assign irq_n = 1'b1;
`endif

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic             hit;
    logic [WIDTH-1:0] po_q, ddr_q, sync_w;

    assign hit = (port_idx == ADDR_W'(p));

    // Output data and direction registers for this port
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        po_q  <= '0;
        ddr_q <= '0;
      end else if (wr_en && hit) begin
        if (sel == SEL_DATA) po_q  <= DI;
        if (sel == SEL_DDR)  ddr_q <= DI;
      end
    end

    assign po_all[p*WIDTH +: WIDTH]   = po_q;
    assign ddr_all[p*WIDTH +: WIDTH]  = ddr_q;
    assign sync_all[p*WIDTH +: WIDTH] = sync_w;

`ifdef GPIO_PORT_BANK_IRQ_EN
    logic [WIDTH-1:0] ier_q, epr_q, ifr_q, ifr_d, edge_w, clr_w;

    gpio_port_sync #(.WIDTH(WIDTH)) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_i  (PI[p*WIDTH +: WIDTH]),
      .epr_i  (epr_q),
      .ddr_i  (ddr_q),
      .edge_o (edge_w),
      .sync_o (sync_w)
    );

    // A new edge beats a same-cycle write-1-to-clear on the same bit
    assign clr_w = (wr_en && hit && sel == SEL_IFR) ? DI : '0;
    assign ifr_d = (ifr_q & ~clr_w) | (armed ? edge_w : '0);

    // Interrupt enable, edge polarity and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ier_q <= '0;
        epr_q <= '0;
        ifr_q <= '0;
      end else begin
        if (wr_en && hit && sel == SEL_IER) ier_q <= DI;
        if (wr_en && hit && sel == SEL_EPR) epr_q <= DI;
        ifr_q <= ifr_d;
      end
    end

    assign ier_all[p*WIDTH +: WIDTH] = ier_q;
    assign epr_all[p*WIDTH +: WIDTH] = epr_q;
    assign ifr_all[p*WIDTH +: WIDTH] = ifr_q;
`else
    gpio_port_sync #(.WIDTH(WIDTH)) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_i  (PI[p*WIDTH +: WIDTH]),
      .sync_o (sync_w)
    );
`endif
  end

  // Read mux: unmapped selects and out-of-range ports fall through to zero
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (port_idx == ADDR_W'(i)) begin
        case (sel)
          SEL_DATA: rd_data_d = (ddr_all[i*WIDTH +: WIDTH] & po_all[i*WIDTH +: WIDTH])
                              | (~ddr_all[i*WIDTH +: WIDTH] & sync_all[i*WIDTH +: WIDTH]);
          SEL_DDR:  rd_data_d = ddr_all[i*WIDTH +: WIDTH];
`ifdef GPIO_PORT_BANK_IRQ_EN
          SEL_IER:  rd_data_d = ier_all[i*WIDTH +: WIDTH];
          SEL_EPR:  rd_data_d = epr_all[i*WIDTH +: WIDTH];
          SEL_IFR:  rd_data_d = ifr_all[i*WIDTH +: WIDTH];
`endif
          default:  rd_data_d = '0;
        endcase
      end
    end
  end

  // Registered read data with a one-cycle valid strobe; DO holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      oe_q   <= 1'b0;
    end else begin
      oe_q <= rd_en;
      if (rd_en) dout_q <= rd_data_d;
    end
  end

  assign DO  = dout_q;
  assign OE  = oe_q;
  assign PO  = po_all;
  assign DDR = ddr_all;

endmodule

// File: tb/tb_gpio_port_bank.sv
// Directed bench for gpio_port_bank; covers both the default build and the
// GPIO_PORT_BANK_IRQ_EN build. A second instance with three ports exercises
// an out-of-range port index.
module tb_gpio_port_bank;
  import gpio_port_bank_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs, we_n;
  logic [3:0]  A;
  logic [7:0]  DI, DO;
  logic        OE, irq_n;
  logic [15:0] PI, PO, DDR;

  logic        cs3, we_n3;
  logic [4:0]  A3;
  logic [7:0]  DI3, DO3;
  logic        OE3, irq3;
  logic [23:0] PI3, PO3, DDR3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gpio_port_bank #(.NUM_PORTS(2), .WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we_n(we_n), .A(A), .DI(DI),
    .DO(DO), .OE(OE), .PI(PI), .PO(PO), .DDR(DDR), .irq_n(irq_n)
  );

  gpio_port_bank #(.NUM_PORTS(3), .WIDTH(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cs(cs3), .we_n(we_n3), .A(A3), .DI(DI3),
    .DO(DO3), .OE(OE3), .PI(PI3), .PO(PO3), .DDR(DDR3), .irq_n(irq3)
  );

  task automatic wr(input int port, input logic [2:0] sel, input logic [7:0] d);
    cs = 1'b1; we_n = 1'b0; A = {1'(port), sel}; DI = d;
    @(negedge clk);
    cs = 1'b0; we_n = 1'b1;
  endtask

  task automatic rd(input int port, input logic [2:0] sel,
                    output logic [7:0] d, output logic oe, output logic oe_after);
    cs = 1'b1; we_n = 1'b1; A = {1'(port), sel};
    @(negedge clk);
    d = DO; oe = OE;
    cs = 1'b0;
    @(negedge clk);
    oe_after = OE;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cs = 1'b0; we_n = 1'b1; A = '0; DI = '0;
    cs3 = 1'b0; we_n3 = 1'b1; A3 = '0; DI3 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] d; logic oe, oe2;
    PI = 16'hFFFF;
    rst_n = 1'b0; cs = 1'b0; we_n = 1'b1; A = '0; DI = '0;
    cs3 = 1'b0; we_n3 = 1'b1; A3 = '0; DI3 = '0;
    repeat (2) @(negedge clk);
    n_chk++; if (DO !== 8'h00) begin n_fail++; $display("FAIL reset_DO: got %h want 00", DO); end
    n_chk++; if (OE !== 1'b0) begin n_fail++; $display("FAIL reset_OE: got %b want 0", OE); end
    n_chk++; if (PO !== 16'h0000) begin n_fail++; $display("FAIL reset_PO: got %h want 0000", PO); end
    n_chk++; if (DDR !== 16'h0000) begin n_fail++; $display("FAIL reset_DDR: got %h want 0000", DDR); end
    n_chk++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL reset_irq_n: got %b want 1", irq_n); end
    rst_n = 1'b1;
    wr(0, SEL_EPR, 8'hFF);
    wr(1, SEL_EPR, 8'hFF);
    wr(0, SEL_IER, 8'hFF);
    wr(1, SEL_IER, 8'hFF);
    @(negedge clk);
    rd(0, SEL_IFR, d, oe, oe2);
    n_chk++; if (d !== 8'h00 || oe !== 1'b1) begin n_fail++; $display("FAIL reset_ifr0: got %h/%b want 00/1", d, oe); end
    rd(1, SEL_IFR, d, oe, oe2);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_ifr1: got %h want 00", d); end
    n_chk++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL reset_fill_irq_n: got %b want 1", irq_n); end
  endtask

  task automatic test_data();
    logic [7:0] d; logic oe, oe2;
    PI = 16'h0000;
    do_reset();
    wr(0, SEL_DDR, 8'hF0);
    wr(0, SEL_DATA, 8'hA5);
    n_chk++; if (PO !== 16'h00A5) begin n_fail++; $display("FAIL data_PO: got %h want 00a5", PO); end
    n_chk++; if (DDR !== 16'h00F0) begin n_fail++; $display("FAIL data_DDR: got %h want 00f0", DDR); end
    PI[7:0] = 8'h0C;
    repeat (2) @(negedge clk);
    rd(0, SEL_DATA, d, oe, oe2);
    n_chk++; if (d !== 8'hAC) begin n_fail++; $display("FAIL data_read: got %h want ac", d); end
    n_chk++; if (oe !== 1'b1 || oe2 !== 1'b0) begin n_fail++; $display("FAIL data_oe_pulse: got %b%b want 10", oe, oe2); end
  endtask

  task automatic test_back_to_back();
    cs = 1'b1; we_n = 1'b1; A = {1'b0, SEL_DDR};
    @(negedge clk);
    n_chk++; if (DO !== 8'hF0 || OE !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got %h/%b want f0/1", DO, OE); end
    A = {1'b0, SEL_DATA};
    @(negedge clk);
    n_chk++; if (DO !== 8'hAC || OE !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got %h/%b want ac/1", DO, OE); end
    cs = 1'b0;
    @(negedge clk);
    n_chk++; if (DO !== 8'hAC || OE !== 1'b0) begin n_fail++; $display("FAIL b2b_hold: got %h/%b want ac/0", DO, OE); end
  endtask

  task automatic test_out_of_range();
    logic [7:0] d; logic oe, oe2;
    PI = 16'h0000;
    do_reset();
    wr(1, SEL_DDR, 8'h3C);
    rd(1, SEL_DDR, d, oe, oe2);
    n_chk++; if (d !== 8'h3C) begin n_fail++; $display("FAIL oor_ddr1: got %h want 3c", d); end
    rd(1, 3'b110, d, oe, oe2);
    n_chk++; if (d !== 8'h00 || oe !== 1'b1) begin n_fail++; $display("FAIL oor_sel110: got %h/%b want 00/1", d, oe); end
    wr(0, 3'b101, 8'hFF);
    wr(1, 3'b110, 8'hFF);
    wr(1, 3'b111, 8'hFF);
    n_chk++; if (PO !== 16'h0000 || DDR !== 16'h3C00) begin n_fail++; $display("FAIL oor_wr_ignored: got %h/%h want 0000/3c00", PO, DDR); end
    cs3 = 1'b1; we_n3 = 1'b0; A3 = {2'd2, SEL_DDR}; DI3 = 8'h5A;
    @(negedge clk);
    A3 = {2'd3, SEL_DDR}; DI3 = 8'hFF;
    @(negedge clk);
    A3 = {2'd3, SEL_DATA};
    @(negedge clk);
    cs3 = 1'b0; we_n3 = 1'b1;
    n_chk++; if (DDR3 !== 24'h5A0000 || PO3 !== 24'h000000) begin n_fail++; $display("FAIL oor_port3_wr: got %h/%h want 5a0000/000000", DDR3, PO3); end
    cs3 = 1'b1; A3 = {2'd2, SEL_DDR};
    @(negedge clk);
    n_chk++; if (DO3 !== 8'h5A || OE3 !== 1'b1) begin n_fail++; $display("FAIL oor_port2_rd: got %h/%b want 5a/1", DO3, OE3); end
    A3 = {2'd3, SEL_DDR};
    @(negedge clk);
    n_chk++; if (DO3 !== 8'h00 || OE3 !== 1'b1) begin n_fail++; $display("FAIL oor_port3_rd: got %h/%b want 00/1", DO3, OE3); end
    cs3 = 1'b0;
    @(negedge clk);
    n_chk++; if (irq3 !== 1'b1) begin n_fail++; $display("FAIL oor_irq3: got %b want 1", irq3); end
  endtask

  task automatic test_reset_mid_access();
    PI = 16'h0000;
    do_reset();
    wr(0, SEL_DATA, 8'h33);
    n_chk++; if (PO !== 16'h0033) begin n_fail++; $display("FAIL mid_po_before: got %h want 0033", PO); end
    cs = 1'b1; we_n = 1'b1; A = {1'b0, SEL_DATA};
    #2 rst_n = 1'b0;
    @(negedge clk);
    n_chk++; if (OE !== 1'b0 || DO !== 8'h00 || PO !== 16'h0000) begin n_fail++; $display("FAIL mid_reset: got %b/%h/%h want 0/00/0000", OE, DO, PO); end
    cs = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (OE !== 1'b0) begin n_fail++; $display("FAIL mid_oe_after: got %b want 0", OE); end
  endtask

`ifdef GPIO_PORT_BANK_IRQ_EN
  task automatic test_irq();
    logic [7:0] d; logic oe, oe2;
    PI = 16'h0000;
    do_reset();
    wr(1, SEL_IER, 8'h01);
    wr(1, SEL_EPR, 8'h01);
    PI[8] = 1'b1;
    repeat (4) @(negedge clk);
    rd(1, SEL_IFR, d, oe, oe2);
    n_chk++; if (d !== 8'h01) begin n_fail++; $display("FAIL irq_ifr_set: got %h want 01", d); end
    n_chk++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL irq_assert: got %b want 0", irq_n); end
    wr(1, SEL_IFR, 8'h01);
    n_chk++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL irq_lag: got %b want 0", irq_n); end
    @(negedge clk);
    n_chk++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL irq_release: got %b want 1", irq_n); end
    PI[9] = 1'b1;
    repeat (4) @(negedge clk);
    PI[9] = 1'b0;
    repeat (4) @(negedge clk);
    rd(1, SEL_IFR, d, oe, oe2);
    n_chk++; if (d !== 8'h02) begin n_fail++; $display("FAIL irq_fall_flag: got %h want 02", d); end
    n_chk++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL irq_masked: got %b want 1", irq_n); end
    wr(1, SEL_IFR, 8'h02);
  endtask

  task automatic test_w1c_race();
    logic [7:0] d; logic oe, oe2;
    PI[8] = 1'b0;
    repeat (4) @(negedge clk);
    PI[8] = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL race_pre_irq: got %b want 0", irq_n); end
    PI[8] = 1'b0;
    repeat (4) @(negedge clk);
    PI[8] = 1'b1;
    repeat (2) @(negedge clk);
    wr(1, SEL_IFR, 8'h01);
    @(negedge clk);
    n_chk++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL race_irq: got %b want 0", irq_n); end
    rd(1, SEL_IFR, d, oe, oe2);
    n_chk++; if (d !== 8'h01) begin n_fail++; $display("FAIL race_ifr: got %h want 01", d); end
  endtask
`else
  task automatic test_no_irq();
    logic [7:0] d; logic oe, oe2;
    PI = 16'h0000;
    do_reset();
    wr(0, SEL_IER, 8'hFF);
    wr(0, SEL_EPR, 8'hFF);
    for (int i = 0; i < 6; i++) begin
      PI = ~PI;
      @(negedge clk);
      n_chk++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL noirq_irq_n: cycle %0d got %b want 1", i, irq_n); end
    end
    rd(0, SEL_IER, d, oe, oe2);
    n_chk++; if (d !== 8'h00 || oe !== 1'b1) begin n_fail++; $display("FAIL noirq_ier: got %h/%b want 00/1", d, oe); end
    rd(0, SEL_IFR, d, oe, oe2);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL noirq_ifr: got %h want 00", d); end
  endtask
`endif

  initial begin
    PI3 = '0;
    test_reset();
    test_data();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_access();
`ifdef GPIO_PORT_BANK_IRQ_EN
    test_irq();
    test_w1c_race();
`else
    test_no_irq();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
